// File: rtl/u_sb.sv
// u_sb: issue scoreboard and hazard scheduler between decode and execute.
// Tracks every architectural register that has a write in flight and holds
// decode on RAW, WAW and load-capacity hazards. Fixed-latency results are
// tracked by a shift pipe that mirrors the execute pipe. Loads are tracked
// by per-register busy bits that the LSU write-back releases.
module u_sb #(
  parameter int ALU_LAT = 4,
  parameter int LD_MAX  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1_a,
  input  logic        iss_rs1_use,
  input  logic [4:0]  iss_rs2_a,
  input  logic        iss_rs2_use,
  input  logic [4:0]  iss_rd_a,
  input  logic        iss_rd_we,
  input  logic        iss_is_ld,
  input  logic        flush,
  input  logic        ld_wb_e,
  input  logic [4:0]  ld_wb_a,
  output logic        iss_stall,
  output logic        iss_fire,
  output logic [31:0] busy,
  output logic [2:0]  ld_cnt,
  output logic        err
);

  localparam logic [2:0] LP_LD_MAX = 3'(LD_MAX);

  // Shift pipe: one {vld, addr} entry per cycle of fixed-latency write.
  logic [ALU_LAT-1:0] r_pipe_vld;
  logic [4:0]         r_pipe_a [ALU_LAT];

  logic [31:0] r_ld_busy;
  logic [2:0]  r_ld_cnt;
  logic        r_err;

  logic [31:0] w_pipe_busy;
  logic [31:0] w_busy;
  logic        w_hazard;
  logic        w_rd_nz;
  logic        w_alu_push;
  logic        w_ld_fire;
  logic        w_ld_set;
  logic        w_wb_dec;
  logic [31:0] w_ld_clr_mask;
  logic [31:0] w_ld_set_mask;
  logic        w_err_evt;

  // Decode the shift pipe into a per-register pending vector.
  always_comb begin
    w_pipe_busy = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      if (r_pipe_vld[i]) begin
        w_pipe_busy[r_pipe_a[i]] = 1'b1;
      end
    end
  end

  // x0 is never tracked, so it can never cause a stall.
  assign w_busy = (r_ld_busy | w_pipe_busy) & ~32'd1;

  // Hazards use registered state only; same-cycle releases do not unstall.
  assign w_hazard = (iss_rs1_use & w_busy[iss_rs1_a])
                  | (iss_rs2_use & w_busy[iss_rs2_a])
                  | (iss_rd_we   & w_busy[iss_rd_a])
                  | (iss_is_ld   & (r_ld_cnt == LP_LD_MAX));

  // Stall ignores flush; flush only suppresses the fire.
  assign iss_stall = iss_valid & w_hazard;
  assign iss_fire  = iss_valid & ~w_hazard & ~flush;

  assign w_rd_nz    = (iss_rd_a != 5'd0);
  assign w_alu_push = iss_fire & iss_rd_we & ~iss_is_ld & w_rd_nz;
  assign w_ld_fire  = iss_fire & iss_is_ld;
  assign w_ld_set   = w_ld_fire & iss_rd_we & w_rd_nz;
  assign w_wb_dec   = ld_wb_e & (r_ld_cnt != 3'd0);

  assign w_ld_clr_mask = ld_wb_e  ? (32'd1 << ld_wb_a)  : 32'd0;
  assign w_ld_set_mask = w_ld_set ? (32'd1 << iss_rd_a) : 32'd0;

  // Any write-back the scoreboard cannot account for is a protocol error.
  assign w_err_evt = ld_wb_e & (~r_ld_busy[ld_wb_a]
                              | (r_ld_cnt == 3'd0)
                              | w_pipe_busy[ld_wb_a]
                              | (w_ld_set & (iss_rd_a == ld_wb_a)));

  // Advance the fixed-latency pipe every cycle; the oldest entry drops off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < ALU_LAT; i++) begin
        r_pipe_a[i] <= 5'd0;
      end
    end else begin
      for (int i = ALU_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_a[i]   <= r_pipe_a[i-1];
      end
      r_pipe_vld[0] <= w_alu_push;
      r_pipe_a[0]   <= w_alu_push ? iss_rd_a : 5'd0;
    end
  end

  // Load busy bits: write-back clears, a new load sets, and set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ld_busy <= '0;
    end else begin
      r_ld_busy <= (r_ld_busy & ~w_ld_clr_mask) | w_ld_set_mask;
    end
  end

  // Outstanding-load count; a write-back at zero leaves the count at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ld_cnt <= 3'd0;
    end else begin
      case ({w_ld_fire, w_wb_dec})
        2'b10:   r_ld_cnt <= r_ld_cnt + 3'd1;
        2'b01:   r_ld_cnt <= r_ld_cnt - 3'd1;
        default: r_ld_cnt <= r_ld_cnt;
      endcase
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_evt;
    end
  end

  assign busy   = w_busy;
  assign ld_cnt = r_ld_cnt;
  assign err    = r_err;

endmodule

// File: tb/tb_u_sb.sv
// tb_u_sb: directed vector table plus randomized run against a
// cycle-indexed reference model of the u_sb scoreboard.
module tb_u_sb;
  localparam int ALU_LAT = 4;
  localparam int LD_MAX  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        iss_valid, iss_rs1_use, iss_rs2_use, iss_rd_we, iss_is_ld, flush, ld_wb_e;
  logic [4:0]  iss_rs1_a, iss_rs2_a, iss_rd_a, ld_wb_a;
  logic        iss_stall, iss_fire, err;
  logic [31:0] busy;
  logic [2:0]  ld_cnt;

  always #5 clk = ~clk;

  u_sb #(.ALU_LAT(ALU_LAT), .LD_MAX(LD_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rs1_a(iss_rs1_a), .iss_rs1_use(iss_rs1_use),
    .iss_rs2_a(iss_rs2_a), .iss_rs2_use(iss_rs2_use),
    .iss_rd_a(iss_rd_a), .iss_rd_we(iss_rd_we), .iss_is_ld(iss_is_ld),
    .flush(flush), .ld_wb_e(ld_wb_e), .ld_wb_a(ld_wb_a),
    .iss_stall(iss_stall), .iss_fire(iss_fire), .busy(busy),
    .ld_cnt(ld_cnt), .err(err)
  );

  // Reference model: per-register last cycle of a fixed-latency write,
  // pending-load flags, load count and error flag, indexed by cycle number.
  int  alu_until [32];
  bit  ldp [32];
  int  mcnt;
  bit  merr;
  int  cyc;

  int n_chk = 0;
  int n_err = 0;

  logic        exp_stall, exp_fire, exp_err, act_stall, act_fire, act_err;
  logic [31:0] exp_busy, act_busy;
  logic [2:0]  exp_cnt, act_cnt;

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic ld; logic fl; logic wbe; logic [4:0] wba;
    logic st; logic fi; logic [31:0] bz; logic [2:0] cn; logic er;
  } vec_t;

  vec_t tbl [30];

  function automatic logic [31:0] bm(input int n);
    return 32'd1 << n;
  endfunction

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic fl,
                              input logic wbe, input logic [4:0] wba,
                              input logic st, input logic fi, input logic [31:0] bz,
                              input logic [2:0] cn, input logic er);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.we = we; t.ld = ld; t.fl = fl; t.wbe = wbe; t.wba = wba;
    t.st = st; t.fi = fi; t.bz = bz; t.cn = cn; t.er = er;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, a, e);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic fl,
                        input logic wbe, input logic [4:0] wba);
    iss_valid = v; iss_rs1_a = rs1; iss_rs1_use = u1; iss_rs2_a = rs2; iss_rs2_use = u2;
    iss_rd_a = rd; iss_rd_we = we; iss_is_ld = ld; flush = fl; ld_wb_e = wbe; ld_wb_a = wba;
  endtask

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      alu_until[r] = -1000;
      ldp[r] = 1'b0;
    end
    mcnt = 0;
    merr = 1'b0;
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = ldp[r] || (alu_until[r] >= cyc);
    return b;
  endfunction

  // One clock: predict and sample at the falling edge, advance the model at
  // the rising edge, return 1 time unit after it.
  task automatic tick();
    logic [31:0] mb;
    logic hz;
    logic ld_set;
    bit dec;
    @(negedge clk);
    mb = m_busy();
    hz = (iss_rs1_use && mb[iss_rs1_a]) || (iss_rs2_use && mb[iss_rs2_a]) ||
         (iss_rd_we && mb[iss_rd_a]) || (iss_is_ld && mcnt == LD_MAX);
    exp_stall = iss_valid && hz;
    exp_fire  = iss_valid && !hz && !flush;
    exp_busy  = mb;
    exp_cnt   = 3'(mcnt);
    exp_err   = merr;
    act_stall = iss_stall; act_fire = iss_fire; act_busy = busy;
    act_cnt   = ld_cnt;    act_err  = err;
    @(posedge clk);
    ld_set = exp_fire && iss_is_ld && iss_rd_we && iss_rd_a != 0;
    if (ld_wb_e && (!ldp[ld_wb_a] || mcnt == 0 || alu_until[ld_wb_a] >= cyc ||
                    (ld_set && iss_rd_a == ld_wb_a)))
      merr = 1'b1;
    if (ld_wb_e) ldp[ld_wb_a] = 1'b0;
    if (ld_set) ldp[iss_rd_a] = 1'b1;
    if (exp_fire && !iss_is_ld && iss_rd_we && iss_rd_a != 0)
      alu_until[iss_rd_a] = cyc + ALU_LAT;
    dec = ld_wb_e && mcnt > 0;
    if (exp_fire && iss_is_ld) mcnt++;
    if (dec) mcnt--;
    cyc++;
    #1;
  endtask

  task automatic chk_model(input string tag, input int idx);
    chk({tag, "_stall"}, idx, 32'(act_stall), 32'(exp_stall));
    chk({tag, "_fire"},  idx, 32'(act_fire),  32'(exp_fire));
    chk({tag, "_busy"},  idx, act_busy,       exp_busy);
    chk({tag, "_cnt"},   idx, 32'(act_cnt),   32'(exp_cnt));
    chk({tag, "_err"},   idx, 32'(act_err),   32'(exp_err));
  endtask

  // Asynchronous reset asserted between edges; state must clear at once.
  task automatic do_reset(input int idx);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    chk("rst_busy",  idx, busy, 32'd0);
    chk("rst_cnt",   idx, 32'(ld_cnt), 32'd0);
    chk("rst_err",   idx, 32'(err), 32'd0);
    chk("rst_stall", idx, 32'(iss_stall), 32'd0);
    m_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int pend [$];
    logic wbe;
    logic [4:0] wba;

    // v rs1 u1 rs2 u2 rd we ld fl wbe wba | stall fire busy cnt err
    tbl[0]  = mk(1, 0,0, 0,0,  5,1,0,0, 0, 0,  0,1, 32'd0,               0,0);
    for (int i = 1; i <= 4; i++)
      tbl[i] = mk(1, 5,1, 1,1,  6,1,0,0, 0, 0,  1,0, bm(5),               0,0);
    tbl[5]  = mk(1, 5,1, 1,1,  6,1,0,0, 0, 0,  0,1, 32'd0,               0,0);
    for (int i = 6; i <= 9; i++)
      tbl[i] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, bm(6),               0,0);
    tbl[10] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, 32'd0,               0,0);
    tbl[11] = mk(1, 0,1, 0,0,  7,1,1,0, 0, 0,  0,1, 32'd0,               0,0);
    tbl[12] = mk(1, 0,1, 0,0,  8,1,1,0, 0, 0,  0,1, bm(7),               1,0);
    tbl[13] = mk(1, 0,1, 0,0,  9,1,1,0, 0, 0,  1,0, bm(7)|bm(8),         2,0);
    tbl[14] = mk(1, 0,1, 0,0,  9,1,1,0, 1, 7,  1,0, bm(7)|bm(8),         2,0);
    tbl[15] = mk(1, 0,1, 0,0,  9,1,1,0, 0, 0,  0,1, bm(8),               1,0);
    tbl[16] = mk(1, 8,1, 0,0, 10,1,0,0, 0, 0,  1,0, bm(8)|bm(9),         2,0);
    tbl[17] = mk(1, 8,1, 0,0, 10,1,0,0, 1, 8,  1,0, bm(8)|bm(9),         2,0);
    tbl[18] = mk(1, 8,1, 0,0, 10,1,0,0, 0, 0,  0,1, bm(9),               1,0);
    tbl[19] = mk(1, 0,1, 0,0, 11,1,1,0, 1, 9,  0,1, bm(9)|bm(10),        1,0);
    tbl[20] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, bm(10)|bm(11),       1,0);
    tbl[21] = mk(0, 0,0, 0,0,  0,0,0,0, 1,11,  0,0, bm(10)|bm(11),       1,0);
    tbl[22] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, bm(10),              0,0);
    tbl[23] = mk(1, 0,0, 0,0,  0,1,0,0, 0, 0,  0,1, 32'd0,               0,0);
    tbl[24] = mk(1, 0,1, 0,1,  0,1,0,0, 0, 0,  0,1, 32'd0,               0,0);
    tbl[25] = mk(1, 1,1, 2,1, 13,1,0,1, 0, 0,  0,0, 32'd0,               0,0);
    tbl[26] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, 32'd0,               0,0);
    tbl[27] = mk(0, 0,0, 0,0,  0,0,0,0, 1,12,  0,0, 32'd0,               0,0);
    tbl[28] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, 32'd0,               0,1);
    tbl[29] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,  0,0, 32'd0,               0,1);

    cyc = 0;
    m_clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(0);

    // Directed table
    for (int i = 0; i < 30; i++) begin
      set_in(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
             tbl[i].we, tbl[i].ld, tbl[i].fl, tbl[i].wbe, tbl[i].wba);
      tick();
      chk("tbl_stall", i, 32'(act_stall), 32'(tbl[i].st));
      chk("tbl_fire",  i, 32'(act_fire),  32'(tbl[i].fi));
      chk("tbl_busy",  i, act_busy,       tbl[i].bz);
      chk("tbl_cnt",   i, 32'(act_cnt),   32'(tbl[i].cn));
      chk("tbl_err",   i, 32'(act_err),   32'(tbl[i].er));
    end

    // Reset in the middle of traffic with writes pending and err set
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    chk("mid_fire_alu", 0, 32'(act_fire), 32'd1);
    set_in(1, 0, 1, 0, 0, 4, 1, 1, 0, 0, 0);
    tick();
    chk("mid_fire_ld", 0, 32'(act_fire), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mid_busy", 0, act_busy, bm(3) | bm(4));
    chk("mid_cnt",  0, 32'(act_cnt), 32'd1);
    chk("mid_err",  0, 32'(act_err), 32'd1);
    do_reset(1);

    // Randomized traffic against the model
    for (int k = 0; k < 900; k++) begin
      if (k % 150 == 149) begin
        do_reset(k);
      end else begin
        pend.delete();
        for (int r = 1; r < 32; r++) if (ldp[r]) pend.push_back(r);
        wbe = 1'b0;
        wba = 5'd0;
        if ($urandom_range(49) == 0) begin
          wbe = 1'b1;
          wba = 5'($urandom_range(31));
        end else if (pend.size() > 0 && $urandom_range(2) == 0) begin
          wbe = 1'b1;
          wba = 5'(pend[$urandom_range(pend.size() - 1)]);
        end
        set_in($urandom_range(3) != 0,
               5'($urandom_range(7)), 1'($urandom_range(1)),
               5'($urandom_range(7)), 1'($urandom_range(1)),
               5'($urandom_range(7)), $urandom_range(3) != 0,
               $urandom_range(2) == 0, $urandom_range(7) == 0,
               wbe, wba);
        tick();
        chk_model("rnd", k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
